// File: rtl/dmem_pkg.sv
// Shared types for the data-memory arbiter: FSM states, requester IDs,
// the latched request record and the address legality rule.
package dmem_pkg;

  localparam int DMEM_ADDR_W = 32;
  localparam int DMEM_DATA_W = 32;

  // Word accesses only: both low address bits must be clear.
  localparam logic [1:0] ALIGN_MASK = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  typedef enum logic {
    REQ_CORE,
    REQ_DBG
  } requester_t;

  typedef struct packed {
    logic                   we;
    logic [DMEM_ADDR_W-1:0] addr;
    logic [DMEM_DATA_W-1:0] wdata;
  } mem_req_t;

  // A request may touch memory only if word aligned and inside the array.
  function automatic logic word_legal(input logic [DMEM_ADDR_W-1:0] addr,
                                      input logic [DMEM_ADDR_W-1:0] limit);
    return ((addr[1:0] & ALIGN_MASK) == 2'b00) && (addr < limit);
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data memory.
interface dmem_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);

  logic              core_req_valid;
  logic              core_req_ready;
  logic              core_req_we;
  logic [ADDR_W-1:0] core_req_addr;
  logic [DATA_W-1:0] core_req_wdata;
  logic              core_rsp_valid;
  logic [DATA_W-1:0] core_rsp_rdata;
  logic              core_rsp_err;

  logic              dbg_req_valid;
  logic              dbg_req_ready;
  logic              dbg_req_we;
  logic [ADDR_W-1:0] dbg_req_addr;
  logic [DATA_W-1:0] dbg_req_wdata;
  logic              dbg_rsp_valid;
  logic [DATA_W-1:0] dbg_rsp_rdata;
  logic              dbg_rsp_err;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter side.
  modport slave (
    input  core_req_valid, core_req_we, core_req_addr, core_req_wdata,
    output core_req_ready, core_rsp_valid, core_rsp_rdata, core_rsp_err,
    input  dbg_req_valid, dbg_req_we, dbg_req_addr, dbg_req_wdata,
    output dbg_req_ready, dbg_rsp_valid, dbg_rsp_rdata, dbg_rsp_err,
    output mem_addr, mem_wdata, mem_we, mem_re,
    input  mem_rdata
  );

  // Requester/memory side.
  modport master (
    output core_req_valid, core_req_we, core_req_addr, core_req_wdata,
    input  core_req_ready, core_rsp_valid, core_rsp_rdata, core_rsp_err,
    output dbg_req_valid, dbg_req_we, dbg_req_addr, dbg_req_wdata,
    input  dbg_req_ready, dbg_rsp_valid, dbg_rsp_rdata, dbg_rsp_err,
    input  mem_addr, mem_wdata, mem_we, mem_re,
    output mem_rdata
  );

endinterface

// File: rtl/dmem_prio_select.sv
// Core-first priority select with a saturating starvation counter that
// hands the slot to the debug port once it has waited MAX_WAIT cycles.
module dmem_prio_select
  import dmem_pkg::*;
#(
  parameter int MAX_WAIT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       core_valid,
  input  logic       dbg_valid,
  input  logic       dbg_accept,
  output requester_t winner,
  output logic       grant_valid
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);

  logic [CW-1:0] wait_cnt;
  logic          starved;

  assign starved     = dbg_valid && (wait_cnt == WAIT_MAX);
  assign grant_valid = core_valid || dbg_valid;

  always_comb begin
    winner = REQ_CORE;
    if (starved || (dbg_valid && !core_valid)) winner = REQ_DBG;
  end

  // Counts every cycle debug is pending but not taken, busy cycles included.
  always_ff @(posedge clk) begin
    if (!rst)                         wait_cnt <= '0;
    else if (!dbg_valid || dbg_accept) wait_cnt <= '0;
    else if (wait_cnt != WAIT_MAX)    wait_cnt <= wait_cnt + 1'b1;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/controller for a single-port 256x32 data memory:
// accept -> ACCESS (one registered memory access) -> RESP (one-cycle pulse).
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DATA_W    = DMEM_DATA_W,
  parameter int ADDR_W    = DMEM_ADDR_W,
  parameter int MEM_WORDS = 256,
  parameter int MAX_WAIT  = 8
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);

  localparam logic [DMEM_ADDR_W-1:0] ADDR_LIMIT = DMEM_ADDR_W'(MEM_WORDS * 4);

  state_t            state;
  requester_t        owner;
  requester_t        winner;
  logic              grant_valid;
  mem_req_t          req_q;
  mem_req_t          sel_req;
  logic              legal_q;
  logic              sel_legal;
  logic              open;
  logic              core_accept;
  logic              dbg_accept;
  logic              accept;
  logic              mem_we_q;
  logic              mem_re_q;
  logic              core_rsp_valid_q;
  logic              core_rsp_err_q;
  logic [DATA_W-1:0] core_rsp_rdata_q;
  logic              dbg_rsp_valid_q;
  logic              dbg_rsp_err_q;
  logic [DATA_W-1:0] dbg_rsp_rdata_q;

  dmem_prio_select #(
    .MAX_WAIT(MAX_WAIT)
  ) u_prio (
    .clk        (clk),
    .rst        (rst),
    .core_valid (bus.core_req_valid),
    .dbg_valid  (bus.dbg_req_valid),
    .dbg_accept (dbg_accept),
    .winner     (winner),
    .grant_valid(grant_valid)
  );

  // A new request can be taken while idle or while the previous one responds.
  assign open = rst && ((state == IDLE) || (state == RESP));

  assign bus.core_req_ready = open && grant_valid && (winner == REQ_CORE);
  assign bus.dbg_req_ready  = open && grant_valid && (winner == REQ_DBG);

  assign core_accept = bus.core_req_valid && bus.core_req_ready;
  assign dbg_accept  = bus.dbg_req_valid && bus.dbg_req_ready;
  assign accept      = core_accept || dbg_accept;

  always_comb begin
    sel_req = '{we: bus.core_req_we, addr: bus.core_req_addr, wdata: bus.core_req_wdata};
    if (winner == REQ_DBG)
      sel_req = '{we: bus.dbg_req_we, addr: bus.dbg_req_addr, wdata: bus.dbg_req_wdata};
  end

  assign sel_legal = word_legal(sel_req.addr, ADDR_LIMIT);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state            <= IDLE;
      owner            <= REQ_CORE;
      req_q            <= '0;
      legal_q          <= 1'b0;
      mem_we_q         <= 1'b0;
      mem_re_q         <= 1'b0;
      core_rsp_valid_q <= 1'b0;
      core_rsp_err_q   <= 1'b0;
      core_rsp_rdata_q <= '0;
      dbg_rsp_valid_q  <= 1'b0;
      dbg_rsp_err_q    <= 1'b0;
      dbg_rsp_rdata_q  <= '0;
    end else begin
      // Response outputs are a single-cycle pulse; cleared unless set below.
      core_rsp_valid_q <= 1'b0;
      core_rsp_err_q   <= 1'b0;
      core_rsp_rdata_q <= '0;
      dbg_rsp_valid_q  <= 1'b0;
      dbg_rsp_err_q    <= 1'b0;
      dbg_rsp_rdata_q  <= '0;

      case (state)
        IDLE, RESP: begin
          if (accept) begin
            state    <= ACCESS;
            owner    <= winner;
            req_q    <= sel_req;
            legal_q  <= sel_legal;
            mem_we_q <= sel_legal && sel_req.we;
            mem_re_q <= sel_legal && !sel_req.we;
          end else begin
            state <= IDLE;
          end
        end

        ACCESS: begin
          state    <= RESP;
          mem_we_q <= 1'b0;
          mem_re_q <= 1'b0;
          if (owner == REQ_CORE) begin
            core_rsp_valid_q <= 1'b1;
            core_rsp_err_q   <= !legal_q;
            core_rsp_rdata_q <= mem_re_q ? bus.mem_rdata : '0;
          end else begin
            dbg_rsp_valid_q <= 1'b1;
            dbg_rsp_err_q   <= !legal_q;
            dbg_rsp_rdata_q <= mem_re_q ? bus.mem_rdata : '0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // Enables are qualified by reset so an access interrupted by reset never
  // commits its write at the edge that abandons it.
  assign bus.mem_addr  = req_q.addr;
  assign bus.mem_wdata = req_q.wdata;
  assign bus.mem_we    = mem_we_q && rst;
  assign bus.mem_re    = mem_re_q && rst;

  assign bus.core_rsp_valid = core_rsp_valid_q;
  assign bus.core_rsp_err   = core_rsp_err_q;
  assign bus.core_rsp_rdata = core_rsp_rdata_q;
  assign bus.dbg_rsp_valid  = dbg_rsp_valid_q;
  assign bus.dbg_rsp_err    = dbg_rsp_err_q;
  assign bus.dbg_rsp_rdata  = dbg_rsp_rdata_q;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Controller and arbiter in front of the single-port word-addressed data memory (256 x 32-bit, asynchronous read, synchronous write).
- Shares the memory between two requesters:
  - the core load/store port (primary);
  - a debug/loader port (secondary, e.g. a UART program loader).
- Each request is accepted with a valid/ready handshake, drives exactly one registered memory access, and returns a one-cycle response pulse.
- Misaligned and out-of-range requests are rejected with an error response; the memory is not touched.

Parameters:
- DATA_W, 32, data width of requests, responses and memory.
- ADDR_W, 32, byte-address width of requests.
- MEM_WORDS, 256, memory depth in words; the legal byte range is 0 .. MEM_WORDS*4-1.
- MAX_WAIT, 8, number of cycles a pending debug request may lose arbitration before it is forced to win.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low (0 = reset)
- core_req_valid  in  1  core request present
- core_req_ready  out  1  core request accepted this cycle
- core_req_we  in  1  1 = store, 0 = load
- core_req_addr  in  ADDR_W  byte address
- core_req_wdata  in  DATA_W  store data
- core_rsp_valid  out  1  one-cycle response pulse
- core_rsp_rdata  out  DATA_W  load data (0 for stores and errors)
- core_rsp_err  out  1  misaligned or out-of-range request
- dbg_req_valid, dbg_req_ready, dbg_req_we, dbg_req_addr, dbg_req_wdata, dbg_rsp_valid, dbg_rsp_rdata, dbg_rsp_err: same directions, widths and meanings as the core_* ports, for the debug port
- mem_addr  out  ADDR_W  byte address to memory
- mem_wdata  out  DATA_W  write data to memory
- mem_we  out  1  memory write enable
- mem_re  out  1  memory read enable
- mem_rdata  in  DATA_W  memory read data (combinational from mem_addr)

Behaviour:
- Clocking and reset:
  - All state updates on the rising edge of clk.
  - rst=0 at an edge forces: state IDLE, wait counter 0, every output low or 0.
  - Reset mid-transaction abandons the transaction: no response pulse, no memory write.
- FSM states: IDLE, ACCESS, RESP.
- Ready and acceptance:
  - *_req_ready is asserted only in IDLE or RESP, and only to the arbitration winner.
  - Ready is combinational on valid.
  - A request is accepted when valid && ready. On acceptance, we/addr/wdata and the winner ID are latched and the state moves to ACCESS.
- ACCESS (exactly one cycle):
  - mem_addr and mem_wdata are driven from the latched request.
  - If the request is legal: mem_we = latched we, mem_re = !latched we, and mem_rdata is captured into the response register on this edge.
  - If the request is illegal (addr[1:0] != 0, or addr >= MEM_WORDS*4): mem_we = mem_re = 0, the error flag is set, and rdata is 0.
  - The state always moves to RESP.
- RESP (one cycle):
  - The winner's *_rsp_valid = 1, with rdata and err from registers.
  - The other port's rsp outputs are 0.
  - Next state: ACCESS if a new request is accepted this cycle, otherwise IDLE.
- Timing:
  - Latency is 2 cycles from the accept edge to the rsp_valid cycle.
  - Sustained throughput is 1 access per 2 cycles.
- mem_we and mem_re are 0 in IDLE and RESP.
- Arbitration:
  - Core wins by default.
  - The wait counter increments by 1 (saturating at MAX_WAIT) each cycle dbg_req_valid=1 and debug is not accepted.
  - When the counter == MAX_WAIT and dbg_req_valid=1, debug wins over core.
  - The counter clears when a debug request is accepted, or when dbg_req_valid=0.
- Simultaneous requests: core wins unless starvation forces debug. The losing port sees ready=0 and must hold its request stable.
- A store to a legal address updates memory at the end of the ACCESS cycle. A load from the same word issued afterwards returns the new data.

Decomposition:
- Package dmem_pkg holds:
  - typedef enum state_t {IDLE, ACCESS, RESP};
  - typedef enum requester_t {REQ_CORE, REQ_DBG};
  - a struct mem_req_t {we, addr, wdata};
  - localparams for the alignment mask.
- Sub-module dmem_prio_select: fixed-priority select plus starvation counter. It outputs the winner ID and a grant-valid signal.

Test Plan:
- Core store: store addr 0x10, data 0xDEADBEEF, then load 0x10 -> mem_we=1 for exactly one cycle; load rsp rdata=0xDEADBEEF, err=0, 2 cycles after accept.
- Collision: core and dbg both valid at one edge (core load 0x0, dbg store 0x4 = 0x12345678) -> core accepted first; dbg accepted in core's RESP cycle; then a load from 0x4 returns 0x12345678.
- Starvation: core valid continuously and dbg valid continuously, MAX_WAIT=8 -> dbg accepted once the counter reaches 8; counter returns to 0; core resumes winning.
- Errors: load 0x6, and store 0x400 with MEM_WORDS=256 -> rsp err=1, rdata=0, mem_we=mem_re=0 throughout; the word at 0x400 & 0x3FC is unchanged.
- Reset during ACCESS of a store to 0x20: rst=0 that cycle -> no rsp_valid, word at 0x20 unchanged, all outputs 0 next cycle, state IDLE.
